// File: rtl/idma_obi_write_issuer_pkg.sv
// Shared helpers for the OBI write issuer.
// Holds only width helpers; the issuer itself works on plain logic vectors.
package idma_obi_write_issuer_pkg;

    // Width of an index over n items. Never zero, so a single-item case still
    // gets a legal one-bit vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that has to reach n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface.
//   clk_i/rst_ni      : clock, asynchronous active-low reset
//   flush_i           : drop all entries
//   testmode_i        : unused here, kept for interface compatibility
//   full_o/empty_o    : status flags
//   usage_o           : entry count (wraps to 0 when exactly full)
//   data_i/push_i     : write port, push is ignored while full
//   data_o/pop_i      : head of queue, pop is ignored while empty
// With FALL_THROUGH=1 a push into an empty FIFO is visible on data_o in the
// same cycle; with FALL_THROUGH=0 data_o is always the stored head.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned           CntW     = ADDR_DEPTH + 1;
    localparam logic [CntW-1:0]       DepthCnt = CntW'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LastPtr  = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    logic                  bypass, do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == DepthCnt);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];

    // A bypassed word popped in the same cycle never touches the storage.
    assign do_push = push_i && !full_o && !(bypass && pop_i);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/idma_obi_write_issuer.sv
// OBI write issuer: turns legalized write beats plus their data into OBI
// write requests, tracks outstanding beats, and folds per-beat errors into one
// completion per 1D transfer.
//   clk_i/rst_ni                    : clock, asynchronous active-low reset
//   meta_valid_i/meta_ready_o       : beat descriptor handshake
//   meta_addr_i                     : word-aligned write address
//   meta_offset_i/meta_tailer_i     : first valid byte / end byte (0 = full word)
//   meta_last_i                     : beat closes its 1D transfer
//   data_valid_i/data_ready_o/data_i: write data, consumed together with meta
//   obi_*                           : OBI A channel (write only) and R channel
//   rsp_valid_o/rsp_ready_i/rsp_err_o: one completion per 1D transfer
//   busy_o                          : a beat is in flight or a completion waits
module idma_obi_write_issuer
    import idma_obi_write_issuer_pkg::*;
#(
    parameter int unsigned  DataWidth      = 32,
    parameter int unsigned  AddrWidth      = 32,
    parameter int unsigned  MaxOutstanding = 4,
    localparam int unsigned StrbWidth      = DataWidth / 8,
    localparam int unsigned OffsetWidth    = idx_width(StrbWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   meta_valid_i,
    output logic                   meta_ready_o,
    input  logic [AddrWidth-1:0]   meta_addr_i,
    input  logic [OffsetWidth-1:0] meta_offset_i,
    input  logic [OffsetWidth-1:0] meta_tailer_i,
    input  logic                   meta_last_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    input  logic [DataWidth-1:0]   data_i,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic                   obi_we_o,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic [StrbWidth-1:0]   obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic                   obi_err_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_err_o,
    output logic                   busy_o
);
    localparam int unsigned             CreditWidth = cnt_width(MaxOutstanding);
    localparam int unsigned             UsageWidth  = idx_width(MaxOutstanding);
    localparam logic [CreditWidth-1:0]  CreditMax   = CreditWidth'(MaxOutstanding);
    localparam logic [StrbWidth-1:0]    AllOnes     = '1;

    // A credit is one granted beat whose completion has not been consumed.
    // Non-last beats return theirs on rvalid; the last beat of a transfer
    // keeps its credit until the backend takes the response, which bounds
    // the response FIFO by the same counter.
    logic [CreditWidth-1:0] credits_q, credits_d;
    logic                   err_acc_q, err_acc_d;

    logic grant;
    logic inflight_empty, inflight_last;
    logic rsp_push, rsp_pop, rsp_empty, rsp_head;
    logic beat_done;

    logic                  inflight_full_unused, rsp_full_unused;
    logic [UsageWidth-1:0] inflight_usage_unused, rsp_usage_unused;

    logic [StrbWidth-1:0] lo_mask, hi_mask;

    // ---------------------------------------------------------------- A channel
    // Reset gating keeps the request quiet even if upstream is already valid.
    assign obi_req_o    = rst_ni & meta_valid_i & data_valid_i & (credits_q < CreditMax);
    assign grant        = obi_req_o & obi_gnt_i;
    assign meta_ready_o = grant;
    assign data_ready_o = grant;

    assign obi_we_o    = 1'b1;
    assign obi_addr_o  = meta_addr_i;
    assign obi_wdata_o = data_i;

    // Bytes from offset upward, and below tailer unless tailer means full word.
    assign lo_mask  = AllOnes << meta_offset_i;
    assign hi_mask  = (meta_tailer_i == '0) ? AllOnes : ~(AllOnes << meta_tailer_i);
    assign obi_be_o = lo_mask & hi_mask;

    // ---------------------------------------------------------------- R channel
    // The in-flight FIFO carries only the last flag; R returns in order.
    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (MaxOutstanding)
    ) i_inflight_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (inflight_full_unused),
        .empty_o    (inflight_empty),
        .usage_o    (inflight_usage_unused),
        .data_i     (meta_last_i),
        .push_i     (grant),
        .data_o     (inflight_last),
        .pop_i      (obi_rvalid_i)
    );

    assign rsp_push  = obi_rvalid_i & inflight_last;
    assign beat_done = obi_rvalid_i & ~inflight_last;

    always_comb begin
        err_acc_d = err_acc_q;
        if (obi_rvalid_i) err_acc_d = inflight_last ? 1'b0 : (err_acc_q | obi_err_i);
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (MaxOutstanding)
    ) i_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (rsp_full_unused),
        .empty_o    (rsp_empty),
        .usage_o    (rsp_usage_unused),
        .data_i     (err_acc_q | obi_err_i),
        .push_i     (rsp_push),
        .data_o     (rsp_head),
        .pop_i      (rsp_pop)
    );

    assign rsp_valid_o = ~rsp_empty;
    assign rsp_err_o   = rsp_head & ~rsp_empty;
    assign rsp_pop     = rsp_valid_o & rsp_ready_i;

    // Grant, non-last completion and response pop may coincide; the
    // intermediate value may wrap but the net result stays in range.
    assign credits_d = credits_q + CreditWidth'(grant)
                                 - CreditWidth'(beat_done)
                                 - CreditWidth'(rsp_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
            err_acc_q <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_acc_q <= err_acc_d;
        end
    end

    assign busy_o = (credits_q != '0);

`ifndef SYNTHESIS
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        obi_rvalid_i |-> !inflight_empty);

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (obi_req_o && !obi_gnt_i) |=> (obi_req_o && $stable(obi_addr_o) &&
                                       $stable(obi_be_o) && $stable(obi_wdata_o)));
`endif

endmodule

// File: tb/tb_idma_obi_write_issuer.sv
module tb_idma_obi_write_issuer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          meta_valid_i = 1'b0;
    logic          meta_ready_o;
    logic [AW-1:0] meta_addr_i = '0;
    logic [1:0]    meta_offset_i = '0;
    logic [1:0]    meta_tailer_i = '0;
    logic          meta_last_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic          data_ready_o;
    logic [DW-1:0] data_i = '0;
    logic          obi_req_o;
    logic          obi_gnt_i = 1'b0;
    logic          obi_we_o;
    logic [AW-1:0] obi_addr_o;
    logic [3:0]    obi_be_o;
    logic [DW-1:0] obi_wdata_o;
    logic          obi_rvalid_i = 1'b0;
    logic          obi_err_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_err_o;
    logic          busy_o;

    idma_obi_write_issuer #(
        .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
        .meta_addr_i(meta_addr_i), .meta_offset_i(meta_offset_i),
        .meta_tailer_i(meta_tailer_i), .meta_last_i(meta_last_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_we_o(obi_we_o),
        .obi_addr_o(obi_addr_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    // Scoreboard / reference model state
    beat_t exp_a[$];      // beats offered, in order, awaiting grant
    bit    r_last_q[$];   // granted beats awaiting completion: last flag
    bit    rsp_q[$];      // transfer completions the backend has yet to take
    bit    err_plan[$];   // forced per-beat error bits for the subordinate
    int    outst = 0;     // beats granted whose completion is not consumed
    bit    acc = 1'b0;    // error seen so far in the current transfer
    int    granted_cnt = 0;
    int    rvalid_cnt = 0;
    int    dut_grants = 0;

    // Environment knobs
    bit gnt_always = 1'b1;
    bit slave_en = 1'b0;
    bit slave_eager = 1'b1;
    bit err_rand = 1'b0;
    int rdy_mode = 1;     // 0 = hold off, 1 = always ready, 2 = random

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] be_of(input int off, input int tail);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (tail == 0 || i < tail);
        return r;
    endfunction

    // ------------------------------------------------------------ subordinate
    always @(posedge clk_i) begin
        #1;
        obi_gnt_i = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            obi_rvalid_i = 1'b0;
            obi_err_i    = 1'b0;
            rvalid_cnt   = 0;
        end else if (slave_en && granted_cnt > rvalid_cnt &&
                     (slave_eager || $urandom_range(0, 2) == 0)) begin
            obi_rvalid_i = 1'b1;
            if (err_plan.size() != 0) obi_err_i = err_plan.pop_front();
            else obi_err_i = err_rand && ($urandom_range(0, 5) == 0);
            rvalid_cnt++;
        end else begin
            obi_rvalid_i = 1'b0;
            obi_err_i    = 1'($urandom_range(0, 1));  // ignored without rvalid
        end
    end

    always @(posedge clk_i) begin
        #1;
        rsp_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    // ------------------------------------------------------------ monitor
    always @(negedge clk_i) begin
        bit    exp_req;
        beat_t b;
        bit    l;
        if (!rst_ni) begin
            chk("rst_obi_req", obi_req_o, 0);
            chk("rst_meta_ready", meta_ready_o, 0);
            chk("rst_data_ready", data_ready_o, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_rsp_err", rsp_err_o, 0);
            chk("rst_busy", busy_o, 0);
            exp_a.delete();
            r_last_q.delete();
            rsp_q.delete();
            outst = 0;
            acc = 1'b0;
            granted_cnt = 0;
        end else begin
            exp_req = meta_valid_i && data_valid_i && (outst < MO);
            chk("obi_req", obi_req_o, exp_req);
            chk("meta_ready", meta_ready_o, exp_req && obi_gnt_i);
            chk("data_ready", data_ready_o, exp_req && obi_gnt_i);
            chk("obi_we", obi_we_o, 1);
            chk("busy", busy_o, outst != 0);
            chk("rsp_valid", rsp_valid_o, rsp_q.size() != 0);
            if (rsp_q.size() != 0) chk("rsp_err", rsp_err_o, rsp_q[0]);
            if (obi_req_o && obi_gnt_i) dut_grants++;

            if (exp_req && obi_gnt_i) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_beat: grant with no beat offered at %0t", $time);
                end else begin
                    b = exp_a.pop_front();
                    chk("obi_addr", obi_addr_o, b.addr);
                    chk("obi_be", obi_be_o, b.be);
                    chk("obi_wdata", obi_wdata_o, b.data);
                end
                r_last_q.push_back(meta_last_i);
                outst++;
                granted_cnt++;
            end
            if (rsp_valid_o && rsp_ready_i && rsp_q.size() != 0) begin
                rsp_q.delete(0);
                outst--;
            end
            if (obi_rvalid_i) begin
                if (r_last_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_beat: rvalid with nothing granted at %0t", $time);
                end else begin
                    l = r_last_q.pop_front();
                    if (l) begin
                        rsp_q.push_back(acc | obi_err_i);
                        acc = 1'b0;
                    end else begin
                        acc = acc | obi_err_i;
                        outst--;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ driver
    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // Caller is aligned one time unit after a rising edge.
    task automatic issue(input logic [31:0] addr, input int off, input int tail,
                         input bit last, input logic [31:0] data, input bit stagger);
        int t;
        beat_t b;
        b.addr = addr;
        b.be   = be_of(off, tail);
        b.data = data;
        exp_a.push_back(b);
        meta_addr_i   = addr;
        meta_offset_i = 2'(off);
        meta_tailer_i = 2'(tail);
        meta_last_i   = last;
        meta_valid_i  = 1'b1;
        data_i        = data;
        if (stagger) sync();
        data_valid_i = 1'b1;
        t = 0;
        forever begin
            @(negedge clk_i);
            if (obi_req_o && obi_gnt_i) break;
            t++;
            if (t > 2000) begin
                n_cmp++; n_bad++;
                $display("FAIL issue_timeout: beat at %0h never granted", addr);
                break;
            end
        end
        sync();
        meta_valid_i = 1'b0;
        data_valid_i = 1'b0;
    endtask

    task automatic rand_xfers(input int n);
        int len, off, tail;
        logic [31:0] base;
        for (int x = 0; x < n; x++) begin
            len  = $urandom_range(1, 4);
            base = $urandom & 32'hFFFF_FFFC;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) sync();
                off  = $urandom_range(0, 3);
                tail = ($urandom_range(0, 1) != 0) ? 0 : off + 1 + $urandom_range(0, 3 - off);
                if (tail == 4) tail = 0;
                issue(base + 32'(4 * k), off, tail, k == len - 1, $urandom,
                      $urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        slave_en = 1'b1;
        rdy_mode = 1;
        while (busy_o && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        @(negedge clk_i);
        chk("drain_busy", busy_o, 0);
        chk("drain_model_empty", exp_a.size() + r_last_q.size() + rsp_q.size(), 0);
        sync();
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sync();

        // Single full beat, immediate completion
        slave_en = 1'b1;
        slave_eager = 1'b1;
        issue(32'h100, 0, 0, 1'b1, 32'hCAFE_0001, 1'b0);
        repeat (4) sync();

        // Partial beats
        issue(32'h104, 1, 3, 1'b1, 32'h1234_5678, 1'b0);
        issue(32'h108, 2, 0, 1'b1, 32'h8765_4321, 1'b0);
        repeat (4) sync();

        // Credit stall: five beats, no completions until the fifth is stuck
        slave_en = 1'b0;
        base = dut_grants;
        fork
            for (int k = 0; k < 5; k++)
                issue(32'h200 + 32'(4 * k), 0, 0, k == 4, $urandom, 1'b0);
            begin
                repeat (10) @(negedge clk_i);
                chk("stall_grants", dut_grants - base, 4);
                chk("stall_req_low", obi_req_o, 0);
                slave_en = 1'b1;
            end
        join
        drain();

        // Error accumulation: error only on beat 1 of 3, then a clean transfer
        err_plan.push_back(1'b0);
        err_plan.push_back(1'b1);
        err_plan.push_back(1'b0);
        err_plan.push_back(1'b0);
        err_plan.push_back(1'b0);
        for (int k = 0; k < 3; k++) issue(32'h300 + 32'(4 * k), 0, 0, k == 2, $urandom, 1'b0);
        for (int k = 0; k < 2; k++) issue(32'h400 + 32'(4 * k), 0, 0, k == 1, $urandom, 1'b0);
        drain();

        // Response backpressure: four completions queue, fifth beat blocked
        rdy_mode = 0;
        fork
            for (int k = 0; k < 5; k++) issue(32'h500 + 32'(4 * k), 0, 0, 1'b1, $urandom, 1'b0);
            begin
                repeat (12) @(negedge clk_i);
                chk("bp_rsp_pending", rsp_valid_o, 1);
                chk("bp_req_low", obi_req_o, 0);
                rdy_mode = 1;
            end
        join
        drain();

        // Randomized traffic
        gnt_always = 1'b0;
        slave_eager = 1'b0;
        err_rand = 1'b1;
        rdy_mode = 2;
        rand_xfers(60);
        drain();

        // Reset with two beats in flight
        gnt_always = 1'b1;
        slave_en = 1'b0;
        issue(32'h600, 0, 0, 1'b0, $urandom, 1'b0);
        issue(32'h604, 0, 0, 1'b0, $urandom, 1'b0);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_req", obi_req_o, 0);
        chk("async_rst_rsp_valid", rsp_valid_o, 0);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b1;
        slave_en = 1'b1;
        slave_eager = 1'b1;
        repeat (20) @(negedge clk_i);
        sync();

        // More random traffic after reset
        gnt_always = 1'b0;
        slave_eager = 1'b0;
        rdy_mode = 2;
        rand_xfers(30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
